// File: rtl/array_wrctl_pkg.sv
// Shared definitions for the array write-port controller.
package array_wrctl_pkg;

  // Controller FSM encoding (2-bit, kept as plain constants for legacy tools).
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t INIT = 2'd1;
  localparam state_t CLR  = 2'd2;

  // Bit positions within par_ctrl.
  localparam int unsigned PAR_CLR = 0;
  localparam int unsigned PAR_DIS = 1;

  // Parity event counter width.
  localparam int unsigned PARCNT_W = 8;

endpackage

// File: rtl/array_wrctl_if.sv
// Bus bundle between the requesters, the write controller and the register array.
interface array_wrctl_if #(
  parameter int unsigned ADDRBIT = 9,
  parameter int unsigned WIDTH   = 32
);
  import array_wrctl_pkg::*;

  // Datapath write stream
  logic                 dp_we;
  logic [ADDRBIT-1:0]   dp_wa;
  logic [WIDTH-1:0]     dp_di;
  // CPU write port
  logic                 cpu_req;
  logic [ADDRBIT-1:0]   cpu_wa;
  logic [WIDTH-1:0]     cpu_di;
  logic                 cpu_ack;
  // Init sweep control
  logic                 init_start;
  logic                 init_busy;
  logic                 init_done;
  // Parity control / status
  logic                 par_clr_req;
  logic                 par_dis;
  logic                 par_errin;
  logic [1:0]           par_ctrl;
  logic [PARCNT_W-1:0]  par_cnt;
  // Array write port
  logic [ADDRBIT-1:0]   wa;
  logic                 we;
  logic [WIDTH-1:0]     di;

  // Controller side
  modport slave (
    input  dp_we, dp_wa, dp_di,
    input  cpu_req, cpu_wa, cpu_di,
    output cpu_ack,
    input  init_start,
    output init_busy, init_done,
    input  par_clr_req, par_dis, par_errin,
    output par_ctrl, par_cnt,
    output wa, we, di
  );

  // Requester / array side
  modport master (
    output dp_we, dp_wa, dp_di,
    output cpu_req, cpu_wa, cpu_di,
    input  cpu_ack,
    output init_start,
    input  init_busy, init_done,
    output par_clr_req, par_dis, par_errin,
    input  par_ctrl, par_cnt,
    input  wa, we, di
  );

endinterface

// File: rtl/array_wrctl_errcnt.sv
// Rising-edge detector on the array parity error plus saturating event counter.
module array_wrctl_errcnt
  import array_wrctl_pkg::*;
(
  input  logic                wclk,
  input  logic                rst_,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                errin_i,
  output logic [PARCNT_W-1:0] cnt_o
);

  logic                errin_q;
  logic [PARCNT_W-1:0] cnt_q;
  logic [PARCNT_W-1:0] cnt_d;
  logic                rise;

  assign rise  = errin_i & ~errin_q;
  assign cnt_o = cnt_q;

  // Next count: clear beats increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Delayed copy for edge detection and counter state.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      errin_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      errin_q <= errin_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/array_wrctl.sv
// Write-port controller: merges datapath, init sweep and CPU writes into the
// array's single write port and manages array parity control.
module array_wrctl
  import array_wrctl_pkg::*;
#(
  parameter int unsigned      ADDRBIT = 9,
  parameter int unsigned      DEPTH   = 512,
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic         wclk,
  input  logic         rst_,
  array_wrctl_if.slave bus
);

  localparam logic [ADDRBIT:0]   DEPTH_C = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] LAST_A  = ADDRBIT'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDRBIT-1:0] sweep_q, sweep_d;
  logic [ADDRBIT-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]   di_q, di_d;
  logic               we_q, we_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               init_busy_q, init_busy_d;
  logic               init_done_q, init_done_d;
  logic [1:0]         par_ctrl_q, par_ctrl_d;

  logic               cpu_grant;
  logic               sweep_step;
  logic               sel_we;
  logic [ADDRBIT-1:0] sel_wa;
  logic [WIDTH-1:0]   sel_di;
  logic               cnt_clr;
  logic               cnt_en;

  // Source arbitration: datapath, then sweep, then CPU; out-of-range drops we.
  always_comb begin
    // ack_q term stops a second grant while the requester is lowering cpu_req
    cpu_grant  = bus.cpu_req && !bus.dp_we && (state_q == IDLE) && !cpu_ack_q;
    sweep_step = (state_q == INIT) && !bus.dp_we;
    sel_we     = 1'b0;
    sel_wa     = wa_q;
    sel_di     = di_q;
    if (bus.dp_we) begin
      sel_we = 1'b1;
      sel_wa = bus.dp_wa;
      sel_di = bus.dp_di;
    end else if (sweep_step) begin
      sel_we = 1'b1;
      sel_wa = sweep_q;
      sel_di = INITVAL;
    end else if (cpu_grant) begin
      sel_we = 1'b1;
      sel_wa = bus.cpu_wa;
      sel_di = bus.cpu_di;
    end
    we_d      = sel_we && ({1'b0, sel_wa} < DEPTH_C);
    wa_d      = sel_wa;
    di_d      = sel_di;
    cpu_ack_d = cpu_grant;
  end

  // FSM next state and sweep address; the sweep holds on datapath cycles.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (bus.init_start) begin
          state_d = INIT;
          sweep_d = '0;
        end
      end
      INIT: begin
        if (sweep_step) begin
          if (sweep_q == LAST_A) state_d = CLR;
          else                   sweep_d = sweep_q + 1'b1;
        end
      end
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    init_busy_d          = (state_d != IDLE);
    init_done_d          = (state_q == CLR);
    par_ctrl_d           = '0;
    par_ctrl_d[PAR_CLR]  = bus.par_clr_req || (state_q == CLR);
    par_ctrl_d[PAR_DIS]  = bus.par_dis;
    cnt_clr              = bus.par_clr_req || ((state_q == IDLE) && bus.init_start);
    cnt_en               = (state_q == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      sweep_q     <= '0;
      wa_q        <= '0;
      we_q        <= 1'b0;
      di_q        <= '0;
      cpu_ack_q   <= 1'b0;
      init_busy_q <= 1'b0;
      init_done_q <= 1'b0;
      par_ctrl_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wa_q        <= wa_d;
      we_q        <= we_d;
      di_q        <= di_d;
      cpu_ack_q   <= cpu_ack_d;
      init_busy_q <= init_busy_d;
      init_done_q <= init_done_d;
      par_ctrl_q  <= par_ctrl_d;
    end
  end

  array_wrctl_errcnt u_errcnt (
    .wclk    (wclk),
    .rst_    (rst_),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .errin_i (bus.par_errin),
    .cnt_o   (bus.par_cnt)
  );

  assign bus.wa        = wa_q;
  assign bus.we        = we_q;
  assign bus.di        = di_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.init_busy = init_busy_q;
  assign bus.init_done = init_done_q;
  assign bus.par_ctrl  = par_ctrl_q;

endmodule

// File: tb/tb_array_wrctl.sv
// Directed self-checking bench for array_wrctl.
module tb_array_wrctl;
  import array_wrctl_pkg::*;

  localparam int unsigned AB = 10;
  localparam int unsigned W  = 32;
  localparam logic [W-1:0] IV = 32'h5A5A0F0F;

  logic wclk;
  logic rst_;
  int   n_chk  = 0;
  int   n_pass = 0;

  array_wrctl_if #(.ADDRBIT(AB), .WIDTH(W)) bus ();

  array_wrctl #(
    .ADDRBIT (AB),
    .DEPTH   (512),
    .WIDTH   (W),
    .INITVAL (IV)
  ) dut (
    .wclk (wclk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // All outputs concatenated: reset value is all zero.
  function automatic logic [63:0] outs();
    return 64'({bus.wa, bus.we, bus.di, bus.cpu_ack, bus.init_busy,
                bus.init_done, bus.par_ctrl, bus.par_cnt});
  endfunction

  initial begin
    rst_            = 1'b0;
    bus.dp_we       = 1'b0;
    bus.dp_wa       = '0;
    bus.dp_di       = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_wa      = '0;
    bus.cpu_di      = '0;
    bus.init_start  = 1'b0;
    bus.par_clr_req = 1'b0;
    bus.par_dis     = 1'b0;
    bus.par_errin   = 1'b0;

    // Reset values
    tick(); tick();
    check("reset_outs", outs(), 64'd0);
    rst_ = 1'b1;
    tick();
    check("idle_outs", outs(), 64'd0);

    // Plain sweep; a second init_start mid-sweep is ignored
    bus.init_start = 1'b1;
    tick();
    check("sw1_start", 64'({bus.init_busy, bus.we}), 64'b10);
    for (int j = 1; j <= 512; j++) begin
      bus.init_start = (j == 50);
      tick();
      check("sw1_write", 64'({bus.init_busy, bus.we, bus.wa, bus.di}),
            64'({1'b1, 1'b1, AB'(j - 1), IV}));
    end
    bus.init_start = 1'b0;
    tick();
    check("sw1_done", 64'({bus.init_done, bus.par_ctrl[0], bus.init_busy, bus.we}), 64'b1100);
    tick();
    check("sw1_after", 64'({bus.init_done, bus.par_ctrl[0], bus.init_busy, bus.we}), 64'b0000);

    // par_dis is registered into par_ctrl[1]
    bus.par_dis = 1'b1;
    tick();
    check("par_dis_on", 64'(bus.par_ctrl), 64'b10);
    bus.par_dis = 1'b0;
    tick();
    check("par_dis_off", 64'(bus.par_ctrl), 64'b00);

    // Parity event counting and saturation
    for (int i = 0; i < 300; i++) begin
      bus.par_errin = 1'b1;
      tick();
      bus.par_errin = 1'b0;
      tick();
      if (i == 9) check("par_cnt10", 64'(bus.par_cnt), 64'd10);
    end
    check("par_sat", 64'(bus.par_cnt), 64'd255);
    bus.par_clr_req = 1'b1;
    tick();
    check("par_clr", 64'({bus.par_ctrl[0], bus.par_cnt}), 64'({1'b1, 8'd0}));
    bus.par_clr_req = 1'b0;
    tick();
    check("par_clr_end", 64'(bus.par_ctrl[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.par_errin = 1'b1;
      tick();
      bus.par_errin = 1'b0;
      tick();
    end
    check("par_cnt3", 64'(bus.par_cnt), 64'd3);
    // clear together with a rising edge: clear wins
    bus.par_errin   = 1'b1;
    bus.par_clr_req = 1'b1;
    tick();
    check("par_clr_wins", 64'(bus.par_cnt), 64'd0);
    bus.par_errin   = 1'b0;
    bus.par_clr_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.par_errin = 1'b1;
      tick();
      bus.par_errin = 1'b0;
      tick();
    end
    check("par_cnt4", 64'(bus.par_cnt), 64'd4);

    // Sweep with one datapath write at sweep address 100, CPU pending throughout
    bus.init_start = 1'b1;
    tick();
    check("sw2_start", 64'({bus.init_busy, bus.par_cnt}), 64'({1'b1, 8'd0}));
    bus.init_start = 1'b0;
    bus.cpu_req    = 1'b1;
    bus.cpu_wa     = AB'(9);
    bus.cpu_di     = 32'h0000_0077;
    bus.dp_wa      = AB'(5);
    bus.dp_di      = 32'hA5A5A5A5;
    for (int j = 1; j <= 513; j++) begin
      bus.dp_we     = (j == 101);
      bus.par_errin = (j == 10);
      tick();
      if (j == 101)
        check("sw2_dp", 64'({bus.cpu_ack, bus.we, bus.wa, bus.di}),
              64'({1'b0, 1'b1, AB'(5), 32'hA5A5A5A5}));
      else
        check("sw2_write", 64'({bus.cpu_ack, bus.we, bus.wa, bus.di}),
              64'({1'b0, 1'b1, AB'((j <= 100) ? j - 1 : j - 2), IV}));
    end
    bus.dp_we     = 1'b0;
    bus.par_errin = 1'b0;
    tick();
    check("sw2_done", 64'({bus.init_done, bus.par_ctrl[0], bus.init_busy, bus.cpu_ack, bus.we}),
          64'b11000);
    tick();
    check("sw2_cpu", 64'({bus.cpu_ack, bus.we, bus.wa, bus.di}),
          64'({1'b1, 1'b1, AB'(9), 32'h0000_0077}));
    tick();
    check("sw2_cpu_once", 64'({bus.cpu_ack, bus.we}), 64'b00);
    bus.cpu_req = 1'b0;
    check("sw2_errin_ign", 64'(bus.par_cnt), 64'd0);

    // CPU request blocked by three datapath cycles
    bus.cpu_req = 1'b1;
    bus.cpu_wa  = AB'(7);
    bus.cpu_di  = 32'h0000_1234;
    for (int k = 0; k < 3; k++) begin
      bus.dp_we = 1'b1;
      bus.dp_wa = AB'(20 + k);
      bus.dp_di = W'(k + 1);
      tick();
      check("cpu_blocked", 64'({bus.cpu_ack, bus.we, bus.wa, bus.di}),
            64'({1'b0, 1'b1, AB'(20 + k), W'(k + 1)}));
    end
    bus.dp_we = 1'b0;
    tick();
    check("cpu_grant", 64'({bus.cpu_ack, bus.we, bus.wa, bus.di}),
          64'({1'b1, 1'b1, AB'(7), 32'h0000_1234}));
    tick();
    check("cpu_no_dbl", 64'({bus.cpu_ack, bus.we}), 64'b00);
    bus.cpu_req = 1'b0;

    // Out-of-range datapath write suppressed
    bus.dp_we = 1'b1;
    bus.dp_wa = AB'(520);
    tick();
    check("dp_oor", 64'(bus.we), 64'd0);
    bus.dp_we = 1'b0;

    // Out-of-range CPU write: acked, no write
    bus.cpu_req = 1'b1;
    bus.cpu_wa  = AB'(600);
    tick();
    check("cpu_oor", 64'({bus.cpu_ack, bus.we}), 64'b10);
    tick();
    check("cpu_oor_end", 64'({bus.cpu_ack, bus.we}), 64'b00);
    bus.cpu_req = 1'b0;

    // Reset mid-sweep at address 200, then restart
    bus.par_dis    = 1'b1;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    for (int j = 1; j <= 201; j++) tick();
    check("rst_pre", 64'({bus.we, bus.wa, bus.par_ctrl[1]}), 64'({1'b1, AB'(200), 1'b1}));
    rst_        = 1'b0;
    bus.par_dis = 1'b0;
    #2;
    check("rst_async", outs(), 64'd0);
    tick();
    rst_ = 1'b1;
    tick();
    check("rst_idle", 64'({bus.init_busy, bus.we}), 64'b00);
    bus.init_start = 1'b1;
    tick();
    check("rst_restart", 64'({bus.init_busy, bus.we}), 64'b10);
    bus.init_start = 1'b0;
    tick();
    check("rst_sw0", 64'({bus.we, bus.wa, bus.di}), 64'({1'b1, AB'(0), IV}));
    tick();
    check("rst_sw1", 64'({bus.we, bus.wa, bus.di}), 64'({1'b1, AB'(1), IV}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/array_wrctl.md
# array_wrctl

Write-port controller placed directly upstream of the parity-protected register array. It merges a never-stalled datapath write stream and a handshaked CPU write port into the array's single write port (wa/we/di). It runs a hardware init sweep that writes INITVAL to every location, and drives the array's par_ctrl inputs. It also accumulates the array's parity-error output into a saturating event counter.

## Interface
- ADDRBIT, 9, address width
- DEPTH, 512, number of array locations
- WIDTH, 32, data width
- INITVAL, 0, value written by init sweep
- rst_  in  1  asynchronous, active-low reset
- wclk  in  1  clock; single domain, shared with array write clock
- dp_we  in  1  datapath write strobe, highest priority, never back-pressured
- dp_wa  in  ADDRBIT  datapath write address
- dp_di  in  WIDTH  datapath write data
- cpu_req  in  1  CPU write request, level, held until cpu_ack
- cpu_wa  in  ADDRBIT  CPU write address
- cpu_di  in  WIDTH  CPU write data
- cpu_ack  out  1  one-cycle grant/complete pulse
- init_start  in  1  pulse, starts init sweep
- init_busy  out  1  high while sweep in progress
- init_done  out  1  one-cycle pulse at sweep completion
- par_clr_req  in  1  pulse, clears array sticky error and par_cnt
- par_dis  in  1  level, disables array parity calculation
- par_errin  in  1  array par_err
- wa  out  ADDRBIT  array write address
- we  out  1  array write enable
- di  out  WIDTH  array write data
- par_ctrl  out  2  [0] parity clear, [1] parity disable
- par_cnt  out  8  saturating count of par_errin rising edges

## Operation
- FSM states: IDLE, INIT, CLR.
  - IDLE -> INIT on init_start.
  - INIT -> CLR after address DEPTH-1 is written.
  - CLR -> IDLE unconditionally after 1 cycle.
- Write source priority, per cycle: dp_we > init sweep (INIT) > CPU (IDLE only).
- Datapath writes:
  - A dp_we in INIT is written; the sweep address counter holds that cycle and resumes next cycle.
- CPU writes:
  - Granted when cpu_req=1, dp_we=0, state=IDLE and cpu_ack=0; the cpu_ack=0 term blocks a double write while req falls.
  - cpu_req is held pending through INIT and CLR.
- Address range:
  - Any source address >= DEPTH suppresses we (no write).
  - A suppressed CPU write is still acked.
- Init sweep:
  - Counter runs 0..DEPTH-1 writing INITVAL.
  - init_start while init_busy=1 is ignored.
- par_ctrl:
  - par_ctrl[1] is registered par_dis.
  - par_ctrl[0] = 1 in the cycle after par_clr_req, and during the CLR cycle.
- par_cnt:
  - Increments on each 0->1 of par_errin while state=IDLE.
  - Saturates at 255.
  - Cleared by par_clr_req, and on entry to INIT.
  - Clear wins over a simultaneous increment.
- Reset mid-sweep aborts the sweep; software must reissue init_start.

## Timing
- All outputs are registered. Reset values: wa=0, we=0, di=0, cpu_ack=0, init_busy=0, init_done=0, par_ctrl=2'b00, par_cnt=0.
- Latency of 1 cycle from a winning request (dp_we, sweep step, or CPU grant) to we/wa/di.
- cpu_ack is asserted in the same cycle its write appears on we. The requester drops or changes cpu_req the cycle after it sees cpu_ack.
- init_busy:
  - Rises the cycle after init_start.
  - Falls in the same cycle init_done pulses.
- The sweep takes DEPTH cycles plus one cycle per interleaved dp_we.
- Completion cycle: the cycle after the last sweep write, init_done=1 and par_ctrl[0]=1 together.
- Edge detection on par_errin uses a 1-cycle delayed copy, so par_cnt updates 1 cycle after the rising edge.

## Structure
- Shared package holds:
  - state encoding IDLE/INIT/CLR (2-bit);
  - PAR_CLR=0 and PAR_DIS=1 bit indices of par_ctrl;
  - PARCNT_W=8.
- One sub-module is natural: array_wrctl_errcnt (edge detect plus 8-bit saturating counter with sync clear).
- FSM, arbitration and output registers stay in the top.

## Test plan
- Reset, then init_start with DEPTH=512 and no other traffic -> 512 consecutive writes wa=0..511 of INITVAL, then init_done=1 and par_ctrl[0]=1 in cycle 513; init_busy is high for cycles 1..512.
- During INIT, dp_we at sweep address 100 with dp_wa=5, dp_di=32'hA5A5A5A5 -> wa=5 written that cycle, sweep resumes at 100 next cycle, total sweep length 513.
- cpu_req with cpu_wa=7, cpu_di=32'h1234 while dp_we is held high for 3 cycles -> no grant for 3 cycles; then exactly one write to wa=7 with cpu_ack=1 in the same cycle.
- cpu_req with cpu_wa=600 (>= DEPTH, ADDRBIT=10) -> cpu_ack pulses, we stays 0.
- par_errin toggled 300 times -> par_cnt=255; then par_clr_req -> par_cnt=0 and par_ctrl[0]=1 the next cycle.
- rst_ asserted at sweep address 200 -> all outputs return to reset values immediately and state=IDLE; a new init_start restarts the sweep from address 0.
